// File: rtl/nios_onchip_mem_pipelined_if.sv
// Avalon-MM pipelined slave bus for the on-chip RAM; parity_inject exists only
// when ONCHIP_MEM_PARITY_EN is defined.
interface nios_onchip_mem_pipelined_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12
);
   logic                      chipselect;
   logic                      read;
   logic                      write;
   logic [ADDR_WIDTH-1:0]     address;
   logic [DATA_WIDTH/8-1:0]   byteenable;
   logic [DATA_WIDTH-1:0]     writedata;
   logic                      waitrequest;
   logic [DATA_WIDTH-1:0]     readdata;
   logic                      readdatavalid;
   logic                      parity_err;

`ifdef ONCHIP_MEM_PARITY_EN
   logic                      parity_inject;

   modport master (
      output chipselect, read, write, address, byteenable, writedata, parity_inject,
      input  waitrequest, readdata, readdatavalid, parity_err
   );
   modport slave (
      input  chipselect, read, write, address, byteenable, writedata, parity_inject,
      output waitrequest, readdata, readdatavalid, parity_err
   );
`else
   modport master (
      output chipselect, read, write, address, byteenable, writedata,
      input  waitrequest, readdata, readdatavalid, parity_err
   );
   modport slave (
      input  chipselect, read, write, address, byteenable, writedata,
      output waitrequest, readdata, readdatavalid, parity_err
   );
`endif
endinterface

// File: rtl/nios_onchip_mem_pipelined.sv
// Pipelined Avalon-MM on-chip RAM: readdatavalid READ_LATENCY edges after the accept edge.
// waitrequest (reset | reset_req | ~clken) freezes the pipeline; ONCHIP_MEM_PARITY_EN adds byte parity.
module nios_onchip_mem_pipelined #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 12,
   parameter int DEPTH        = 4096,
   parameter int READ_LATENCY = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        clken,
   input  logic                        reset_req,
   nios_onchip_mem_pipelined_if.slave  bus
);
   localparam int NB = DATA_WIDTH / 8;
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

   typedef struct packed {
      logic                  vld;
      logic                  perr;
      logic [DATA_WIDTH-1:0] dat;
   } rd_stage_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic          stall;
   logic          acc;
   logic          wr_acc;
   logic          rd_acc;
   logic          in_range;
   logic [IW-1:0] idx;
   logic          rd_perr;
   rd_stage_t     s0;
   rd_stage_t     s1;
   rd_stage_t     rd_out;

   assign stall    = reset | reset_req | ~clken;
   assign acc      = bus.chipselect & (bus.read | bus.write) & ~stall;
   assign wr_acc   = acc & bus.write;
   // A simultaneous read+write is treated as a plain write.
   assign rd_acc   = acc & bus.read & ~bus.write;
   assign in_range = {1'b0, bus.address} < DEPTH_EXT;
   assign idx      = bus.address[IW-1:0];

   always_ff @(posedge clk) begin
      if (wr_acc && in_range) begin
         for (int i = 0; i < NB; i++) begin
            if (bus.byteenable[i]) begin
               mem[idx][i*8 +: 8] <= bus.writedata[i*8 +: 8];
            end
         end
      end
   end

`ifdef ONCHIP_MEM_PARITY_EN
   logic [NB-1:0] par_mem [DEPTH];

   function automatic logic [NB-1:0] byte_par(input logic [DATA_WIDTH-1:0] d);
      logic [NB-1:0] p;
      for (int i = 0; i < NB; i++) begin
         p[i] = ^d[i*8 +: 8];
      end
      return p;
   endfunction

   // Injection flips the stored bit so the next read of that byte reports an error.
   always_ff @(posedge clk) begin
      if (wr_acc && in_range) begin
         for (int i = 0; i < NB; i++) begin
            if (bus.byteenable[i]) begin
               par_mem[idx][i] <= (^bus.writedata[i*8 +: 8]) ^ bus.parity_inject;
            end
         end
      end
   end

   assign rd_perr = in_range && (|(byte_par(mem[idx]) ^ par_mem[idx]));
`else
   assign rd_perr = 1'b0;
`endif

   // s0 is the RAM output register loaded on the accept edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         s0 <= '0;
      end else if (!stall) begin
         s0.vld  <= rd_acc;
         s0.perr <= rd_acc & rd_perr;
         if (rd_acc) begin
            s0.dat <= in_range ? mem[idx] : '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= '0;
      end else if (!stall) begin
         s1 <= s0;
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         rd_stage_t s2;

         always_ff @(posedge clk) begin
            if (reset) begin
               s2 <= '0;
            end else if (!stall) begin
               s2 <= s1;
            end
         end

         assign rd_out = s2;
      end else begin : g_lat1
         assign rd_out = s1;
      end
   endgenerate

   assign bus.waitrequest   = stall;
   assign bus.readdatavalid = rd_out.vld;
   assign bus.readdata      = rd_out.dat;
   assign bus.parity_err    = rd_out.perr;

endmodule

// File: tb/tb_nios_onchip_mem_pipelined.sv
// Directed bench: three RAM instances (lat 1, lat 2, depth 3000) share one stimulus bus.
// Inputs change 1 ns after each rising edge; outputs are checked at that same point.
module tb_nios_onchip_mem_pipelined;
   logic        clk = 1'b0;
   logic        reset;
   logic        clken;
   logic        reset_req;
   logic        cs;
   logic        rd;
   logic        wr;
   logic [11:0] addr;
   logic [3:0]  be;
   logic [31:0] wd;
   logic        pinj;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   nios_onchip_mem_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) bus_a ();
   nios_onchip_mem_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) bus_b ();
   nios_onchip_mem_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) bus_c ();

   assign bus_a.chipselect = cs;   assign bus_b.chipselect = cs;   assign bus_c.chipselect = cs;
   assign bus_a.read       = rd;   assign bus_b.read       = rd;   assign bus_c.read       = rd;
   assign bus_a.write      = wr;   assign bus_b.write      = wr;   assign bus_c.write      = wr;
   assign bus_a.address    = addr; assign bus_b.address    = addr; assign bus_c.address    = addr;
   assign bus_a.byteenable = be;   assign bus_b.byteenable = be;   assign bus_c.byteenable = be;
   assign bus_a.writedata  = wd;   assign bus_b.writedata  = wd;   assign bus_c.writedata  = wd;
`ifdef ONCHIP_MEM_PARITY_EN
   assign bus_a.parity_inject = pinj;
   assign bus_b.parity_inject = pinj;
   assign bus_c.parity_inject = pinj;
`endif

   nios_onchip_mem_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(4096), .READ_LATENCY(1)) dut_a (
      .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req), .bus(bus_a.slave));
   nios_onchip_mem_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(4096), .READ_LATENCY(2)) dut_b (
      .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req), .bus(bus_b.slave));
   nios_onchip_mem_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(3000), .READ_LATENCY(1)) dut_c (
      .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req), .bus(bus_c.slave));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic idle();
      cs   = 1'b0;
      rd   = 1'b0;
      wr   = 1'b0;
      addr = '0;
      be   = '0;
      wd   = '0;
   endtask

   task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] b);
      cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; wd = d; be = b;
      step();
      idle();
   endtask

   // Read on the latency-1 instance: valid exactly one edge after acceptance.
   task automatic read_a(input string tag, input logic [11:0] a, input logic [31:0] exp,
                         input logic exp_perr);
      cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
      step();
      idle();
      check({tag, "_early"}, 32'(bus_a.readdatavalid), 32'd0);
      step();
      check({tag, "_vld"}, 32'(bus_a.readdatavalid), 32'd1);
      check({tag, "_dat"}, bus_a.readdata, exp);
      check({tag, "_perr"}, 32'(bus_a.parity_err), 32'(exp_perr));
      step();
      check({tag, "_pulse"}, 32'(bus_a.readdatavalid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      reset = 1'b1; clken = 1'b1; reset_req = 1'b0; pinj = 1'b0;
      step();
      step();
      check("rst_rdv_a",  32'(bus_a.readdatavalid), 32'd0);
      check("rst_rdat_a", bus_a.readdata,           32'd0);
      check("rst_perr_a", 32'(bus_a.parity_err),    32'd0);
      check("rst_rdv_b",  32'(bus_b.readdatavalid), 32'd0);
      check("rst_rdat_b", bus_b.readdata,           32'd0);
      check("rst_wait",   32'(bus_a.waitrequest),   32'd1);
      reset = 1'b0;
      #1;
      check("wait_idle", 32'(bus_a.waitrequest), 32'd0);

      // Full-word write then readback.
      do_write(12'h010, 32'hDEADBEEF, 4'hF);
      read_a("t1", 12'h010, 32'hDEADBEEF, 1'b0);

      // Partial byte-enable merge.
      do_write(12'h020, 32'h11223344, 4'hF);
      do_write(12'h020, 32'hAABBCCDD, 4'b0101);
      read_a("t2", 12'h020, 32'h11BB33DD, 1'b0);

      // Back-to-back reads on both latencies.
      for (int i = 0; i < 4; i++) do_write(12'(i), 32'(i), 4'hF);
      for (int i = 0; i < 7; i++) begin
         if (i < 4) begin
            cs = 1'b1; rd = 1'b1; addr = 12'(i);
         end else begin
            idle();
         end
         step();
         check("b2b_l1_vld", 32'(bus_a.readdatavalid), 32'(i >= 1 && i <= 4));
         if (i >= 1 && i <= 4) check("b2b_l1_dat", bus_a.readdata, 32'(i - 1));
         check("b2b_l2_vld", 32'(bus_b.readdatavalid), 32'(i >= 2 && i <= 5));
         if (i >= 2 && i <= 5) check("b2b_l2_dat", bus_b.readdata, 32'(i - 2));
      end

      // Freeze for three cycles right after a read is accepted.
      do_write(12'h005, 32'h55AA55AA, 4'hF);
      cs = 1'b1; rd = 1'b1; addr = 12'h005;
      step();
      idle();
      clken = 1'b0;
      #1;
      for (int j = 0; j < 3; j++) begin
         check("frz_wait", 32'(bus_a.waitrequest), 32'd1);
         step();
         check("frz_vld", 32'(bus_a.readdatavalid), 32'd0);
      end
      clken = 1'b1;
      #1;
      check("frz_wait_end", 32'(bus_a.waitrequest), 32'd0);
      step();
      check("frz_vld_late", 32'(bus_a.readdatavalid), 32'd1);
      check("frz_dat",      bus_a.readdata,           32'h55AA55AA);
      step();
      check("frz_pulse",    32'(bus_a.readdatavalid), 32'd0);

      // reset_req stalls and blocks writes.
      reset_req = 1'b1;
      #1;
      check("rreq_wait", 32'(bus_a.waitrequest), 32'd1);
      do_write(12'h010, 32'h00000000, 4'hF);
      reset_req = 1'b0;
      read_a("rreq", 12'h010, 32'hDEADBEEF, 1'b0);

      // Read and write together: write happens, no readdatavalid.
      cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 12'h040; wd = 32'h0BADC0DE; be = 4'hF;
      step();
      idle();
      step();
      check("rw_no_vld", 32'(bus_a.readdatavalid), 32'd0);
      step();
      check("rw_no_vld2", 32'(bus_a.readdatavalid), 32'd0);
      read_a("rw", 12'h040, 32'h0BADC0DE, 1'b0);

      // Out-of-range on the 3000-word instance.
      do_write(12'd3500, 32'hFFFFFFFF, 4'hF);
      cs = 1'b1; rd = 1'b1; addr = 12'd3500;
      step();
      idle();
      step();
      check("oor_vld",   32'(bus_c.readdatavalid), 32'd1);
      check("oor_dat",   bus_c.readdata,           32'd0);
      check("oor_perr",  32'(bus_c.parity_err),    32'd0);
      check("inr_dat_a", bus_a.readdata,           32'hFFFFFFFF);

      // Reset with a read in flight and a write on the reset edge.
      do_write(12'h030, 32'hCAFEF00D, 4'hF);
      cs = 1'b1; rd = 1'b1; addr = 12'h010;
      step();
      idle();
      reset = 1'b1;
      cs = 1'b1; wr = 1'b1; addr = 12'h030; wd = 32'h12345678; be = 4'hF;
      step();
      idle();
      check("rstf_vld_c",  32'(bus_c.readdatavalid), 32'd0);
      check("rstf_dat_c",  bus_c.readdata,           32'd0);
      check("rstf_perr_c", 32'(bus_c.parity_err),    32'd0);
      check("rstf_vld_a",  32'(bus_a.readdatavalid), 32'd0);
      step();
      check("rstf_vld_c2", 32'(bus_c.readdatavalid), 32'd0);
      reset = 1'b0;
      read_a("rstwr", 12'h030, 32'hCAFEF00D, 1'b0);

`ifdef ONCHIP_MEM_PARITY_EN
      pinj = 1'b1;
      do_write(12'h050, 32'h00000001, 4'hF);
      pinj = 1'b0;
      read_a("par_inj", 12'h050, 32'h00000001, 1'b1);
      do_write(12'h050, 32'h00000001, 4'hF);
      read_a("par_ok", 12'h050, 32'h00000001, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/nios_onchip_mem_pipelined.md
# nios_onchip_mem_pipelined

Parametrised on-chip RAM for the Nios II system, exposed as a pipelined Avalon-MM slave. It generalises the fixed 4096 x 32 single-port memory with configurable width, depth and read latency. It adds `readdatavalid`/`waitrequest` flow control, out-of-range address handling and optional per-byte parity. It sits on the system interconnect as the CPU's instruction/data scratch memory.

## Interface
- `DATA_WIDTH`, 32, data bus width in bits; a multiple of 8, range 8..128.
- `ADDR_WIDTH`, 12, word-address width.
- `DEPTH`, 4096, number of words; must satisfy `DEPTH <= 2**ADDR_WIDTH`.
- `READ_LATENCY`, 1, accepted-read to `readdatavalid` latency; legal values are 1 or 2.

- `clk`  in  1  single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `clken`  in  1  clock enable; low freezes the block.
- `reset_req`  in  1  reset-request; while high, behaves as `clken`=0.
- `chipselect`  in  1  slave select.
- `read`  in  1  read request.
- `write`  in  1  write request.
- `address`  in  ADDR_WIDTH  word address.
- `byteenable`  in  DATA_WIDTH/8  per-byte write enable.
- `writedata`  in  DATA_WIDTH  write data.
- `waitrequest`  out  1  slave stall.
- `readdata`  out  DATA_WIDTH  read data.
- `readdatavalid`  out  1  marks the cycle in which `readdata` is valid.
- `parity_err`  out  1  parity mismatch on the returned word; tied to 0 unless parity is compiled in.

## Operation
- Storage is `DEPTH` words. RAM contents are not initialised and are not cleared by `reset`.
- `waitrequest` = `reset | reset_req | ~clken`. This signal is combinational.
- A request is accepted on a rising edge when `chipselect & (read | write) & ~waitrequest`.
- Accepted write:
  - Each byte i with `byteenable[i]`=1 is updated.
  - Other bytes keep their value.
  - `byteenable` = 0 is a legal no-op.
- Accepted read: the word at `address` enters the read pipeline.
- `read` and `write` both high: the write is performed and the read is ignored. No `readdatavalid` is produced.
- Out-of-range address (`address >= DEPTH`):
  - Writes are dropped.
  - Reads complete normally with `readdata`=0.
- Read pipeline:
  - `READ_LATENCY` stages of valid/data registers.
  - Stage 2 exists only when `READ_LATENCY`=2.
- Freeze (`clken`=0 or `reset_req`=1):
  - All pipeline registers hold their values.
  - `readdatavalid` keeps its last value but is only meaningful for one cycle. The interconnect must not sample during a freeze.
  - Once the freeze ends, in-flight reads resume from where they stopped.
- `reset`, including mid-operation:
  - `readdatavalid` = 0, `readdata` = 0, `parity_err` = 0.
  - All in-flight reads are discarded.
  - Writes on the reset edge are not performed.

## Timing
- Write accepted at edge k: the new data is readable by a read accepted at edge k+1.
- Read accepted at edge k:
  - `readdatavalid`=1 and `readdata` are valid after edge k+`READ_LATENCY`, for exactly one cycle.
  - This assumes no freeze in between. Each frozen cycle adds one cycle.
- Throughput is one access per cycle. Back-to-back reads produce back-to-back `readdatavalid` pulses, in order.
- Write at edge k followed by a read of the same address at edge k+1 returns the new data.
- `parity_err` is aligned with `readdatavalid`, in the same cycle.

## Configuration
- Macro: `ONCHIP_MEM_PARITY_EN`.
- When defined:
  - One even-parity bit is stored per byte, computed from `writedata` on the write.
  - On each returned read, parity is recomputed. `parity_err`=1 in the `readdatavalid` cycle if any byte mismatches.
  - Out-of-range reads give `parity_err`=0.
  - An extra input `parity_inject` (1 bit) is added. When high on an accepted write, the stored parity of every enabled byte is inverted.
- When undefined:
  - No parity storage and no `parity_inject` port.
  - `parity_err` is constant 0.

## Test plan
- Reset, then write `0xDEADBEEF` @`0x010` with `byteenable`=`4'hF`, then read @`0x010` (`READ_LATENCY`=1) -> `readdatavalid` one cycle after acceptance, `readdata`=`0xDEADBEEF`, `parity_err`=0.
- Write `0x11223344` @`0x020`, then write `0xAABBCCDD` with `byteenable`=`4'b0101`, then read -> `0x11BB33DD`.
- `READ_LATENCY`=2; reads of @0..3 on 4 consecutive cycles (preloaded with 0..3) -> 4 consecutive `readdatavalid` pulses starting 2 cycles after the first read, data 0,1,2,3 in order.
- Read @5, then drop `clken` for 3 cycles right after acceptance -> `waitrequest`=1 for those 3 cycles, `readdatavalid` delayed by 3 cycles, correct data returned.
- `DEPTH`=3000: write `0xFFFFFFFF` @3500, read @3500 -> `readdata`=0 with `readdatavalid`. Then assert `reset` with a read in flight -> no `readdatavalid`, outputs 0.
- With `ONCHIP_MEM_PARITY_EN`: write `0x00000001` with `parity_inject`=1, read it back -> `readdata`=`0x00000001`, `parity_err`=1. Rewrite without inject -> `parity_err`=0.
